// File: rtl/cr_kme_nibble_pkg.sv
// rtl/cr_kme_nibble_pkg.sv - shared types and helpers for the KME nibble transmitter
package cr_kme_nibble_pkg;

  localparam int NIB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] nib;
    logic       err;
  } nib_norm_t;

  // Map a requested nibble count onto 1..nib_max; zero means a full word,
  // anything above nib_max is clamped to a full word and flagged.
  function automatic nib_norm_t norm_nibbles(input logic [2:0] n, input int unsigned nib_max);
    nib_norm_t r;
    r.err = (32'(n) > nib_max);
    r.nib = ((n == 3'd0) || r.err) ? 3'(nib_max) : n;
    return r;
  endfunction

endpackage

// File: rtl/cr_kme_nibble_tx.sv
// rtl/cr_kme_nibble_tx.sv - word-to-nibble serializer in front of the KME stall-controlled FIFO
module cr_kme_nibble_tx
  import cr_kme_nibble_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic [2:0]        in_nibbles,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NIB_W-1:0]  fifo_in,
  output logic              fifo_in_valid,
  input  logic              fifo_in_stall,
  output logic              busy,
  output logic [CNT_W-1:0]  words_sent,
  output logic              proto_err
);

  localparam int NIB_MAX = WORD_W / NIB_W;

  state_t            state;
  logic [WORD_W-1:0] sh;
  logic [2:0]        rem;
  logic              wr;
  logic              last_wr;
  logic              accept;
  nib_norm_t         norm;

  // Write strobe, handshake and normalized count; stall is honoured the same
  // cycle so a full FIFO is never written.
  always_comb begin
    wr            = (state == SEND) && !fifo_in_stall;
    last_wr       = wr && (rem == 3'd1);
    in_ready      = (state == IDLE) || last_wr;
    accept        = in_valid && in_ready;
    fifo_in_valid = wr;
    fifo_in       = sh[NIB_W-1:0];
    busy          = (state == SEND);
    norm          = norm_nibbles(in_nibbles, NIB_MAX);
  end

  // Load/shift engine: a new accept on the last nibble reloads directly,
  // which keeps consecutive words bubble-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      rem        <= '0;
      words_sent <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (last_wr && !(&words_sent)) begin
        words_sent <= words_sent + 1'b1;
      end
      if (accept) begin
        state     <= SEND;
        sh        <= in_data;
        rem       <= norm.nib;
        proto_err <= proto_err | norm.err;
      end else if (wr) begin
        sh  <= sh >> NIB_W;
        rem <= rem - 3'd1;
        if (rem == 3'd1) begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cr_kme_nibble_tx.sv
// tb/tb_cr_kme_nibble_tx.sv - directed self-checking bench for cr_kme_nibble_tx
`timescale 1ns/1ps
module tb_cr_kme_nibble_tx;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [2:0]  in_nibbles;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  fifo_in;
  logic        fifo_in_valid;
  logic        fifo_in_stall;
  logic        busy;
  logic [15:0] words_sent;
  logic        proto_err;

  int vecs = 0;
  int errs = 0;

  cr_kme_nibble_tx #(.WORD_W(16), .CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_data       (in_data),
    .in_nibbles    (in_nibbles),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fifo_in       (fifo_in),
    .fifo_in_valid (fifo_in_valid),
    .fifo_in_stall (fifo_in_stall),
    .busy          (busy),
    .words_sent    (words_sent),
    .proto_err     (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check the outputs
  // that cycle presents before the next rising edge commits it.
  task automatic cyc(input string tag, input logic v, input logic [15:0] d, input logic [2:0] n,
                     input logic s, input logic ev, input logic [3:0] en, input logic er);
    @(negedge clk);
    in_valid = v; in_data = d; in_nibbles = n; fifo_in_stall = s;
    #1;
    chk({tag, "_valid"}, 32'(fifo_in_valid), 32'(ev));
    if (ev) chk({tag, "_nib"}, 32'(fifo_in), 32'(en));
    chk({tag, "_ready"}, 32'(in_ready), 32'(er));
  endtask

  task automatic idle_chk(input string tag, input logic [15:0] ws, input logic pe);
    cyc({tag, "_idle"}, 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ws"}, 32'(words_sent), 32'(ws));
    chk({tag, "_perr"}, 32'(proto_err), 32'(pe));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_nibbles = '0; fifo_in_stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(fifo_in_valid), 32'd0);
    chk("rst_fifo_in", 32'(fifo_in), 32'd0);
    chk("rst_ws", 32'(words_sent), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // single word, no stall
    cyc("t1_acc", 1, 16'hA5C3, 3'd4, 0, 0, 4'h0, 1);
    cyc("t1_n0", 0, 16'h0, 3'd0, 0, 1, 4'h3, 0);
    cyc("t1_n1", 0, 16'h0, 3'd0, 0, 1, 4'hC, 0);
    cyc("t1_n2", 0, 16'h0, 3'd0, 0, 1, 4'h5, 0);
    cyc("t1_n3", 0, 16'h0, 3'd0, 0, 1, 4'hA, 1);
    idle_chk("t1", 16'd1, 1'b0);

    // back-to-back words with valid held
    cyc("b2b_c0", 1, 16'h1234, 3'd4, 0, 0, 4'h0, 1);
    cyc("b2b_c1", 1, 16'h5678, 3'd4, 0, 1, 4'h4, 0);
    cyc("b2b_c2", 1, 16'h5678, 3'd4, 0, 1, 4'h3, 0);
    cyc("b2b_c3", 1, 16'h5678, 3'd4, 0, 1, 4'h2, 0);
    cyc("b2b_c4", 1, 16'h5678, 3'd4, 0, 1, 4'h1, 1);
    cyc("b2b_c5", 0, 16'h0, 3'd0, 0, 1, 4'h8, 0);
    cyc("b2b_c6", 0, 16'h0, 3'd0, 0, 1, 4'h7, 0);
    cyc("b2b_c7", 0, 16'h0, 3'd0, 0, 1, 4'h6, 0);
    cyc("b2b_c8", 0, 16'h0, 3'd0, 0, 1, 4'h5, 1);
    idle_chk("b2b", 16'd3, 1'b0);

    // stall on cycles 2..4 of the word
    cyc("st_c0", 1, 16'hBEEF, 3'd4, 0, 0, 4'h0, 1);
    cyc("st_c1", 0, 16'h0, 3'd0, 0, 1, 4'hF, 0);
    cyc("st_c2", 0, 16'h0, 3'd0, 1, 0, 4'h0, 0);
    cyc("st_c3", 0, 16'h0, 3'd0, 1, 0, 4'h0, 0);
    cyc("st_c4", 0, 16'h0, 3'd0, 1, 0, 4'h0, 0);
    chk("st_busy", 32'(busy), 32'd1);
    cyc("st_c5", 0, 16'h0, 3'd0, 0, 1, 4'hE, 0);
    cyc("st_c6", 0, 16'h0, 3'd0, 0, 1, 4'hE, 0);
    cyc("st_c7", 0, 16'h0, 3'd0, 0, 1, 4'hB, 1);
    idle_chk("st", 16'd4, 1'b0);

    // partial word of two nibbles
    cyc("p2_acc", 1, 16'h00C7, 3'd2, 0, 0, 4'h0, 1);
    cyc("p2_n0", 0, 16'h0, 3'd0, 0, 1, 4'h7, 0);
    cyc("p2_n1", 0, 16'h0, 3'd0, 0, 1, 4'hC, 1);
    idle_chk("p2", 16'd5, 1'b0);

    // zero count means full word
    cyc("z_acc", 1, 16'h4321, 3'd0, 0, 0, 4'h0, 1);
    cyc("z_n0", 0, 16'h0, 3'd0, 0, 1, 4'h1, 0);
    cyc("z_n1", 0, 16'h0, 3'd0, 0, 1, 4'h2, 0);
    cyc("z_n2", 0, 16'h0, 3'd0, 0, 1, 4'h3, 0);
    cyc("z_n3", 0, 16'h0, 3'd0, 0, 1, 4'h4, 1);
    idle_chk("z", 16'd6, 1'b0);

    // oversized count: clamped and flagged
    cyc("o_acc", 1, 16'h9876, 3'd6, 0, 0, 4'h0, 1);
    cyc("o_n0", 0, 16'h0, 3'd0, 0, 1, 4'h6, 0);
    cyc("o_n1", 0, 16'h0, 3'd0, 0, 1, 4'h7, 0);
    cyc("o_n2", 0, 16'h0, 3'd0, 0, 1, 4'h8, 0);
    cyc("o_n3", 0, 16'h0, 3'd0, 0, 1, 4'h9, 1);
    idle_chk("o", 16'd7, 1'b1);

    // single-nibble word; error flag stays sticky
    cyc("s1_acc", 1, 16'h000F, 3'd1, 0, 0, 4'h0, 1);
    cyc("s1_n0", 0, 16'h0, 3'd0, 0, 1, 4'hF, 1);
    idle_chk("s1", 16'd8, 1'b1);

    // reset after the second nibble
    cyc("r_acc", 1, 16'hDCBA, 3'd4, 0, 0, 4'h0, 1);
    cyc("r_n0", 0, 16'h0, 3'd0, 0, 1, 4'hA, 0);
    cyc("r_n1", 0, 16'h0, 3'd0, 0, 1, 4'hB, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("r_valid", 32'(fifo_in_valid), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_ws", 32'(words_sent), 32'd0);
    chk("r_perr", 32'(proto_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    cyc("r2_acc", 1, 16'h1357, 3'd4, 0, 0, 4'h0, 1);
    cyc("r2_n0", 0, 16'h0, 3'd0, 0, 1, 4'h7, 0);
    cyc("r2_n1", 0, 16'h0, 3'd0, 0, 1, 4'h5, 0);
    cyc("r2_n2", 0, 16'h0, 3'd0, 0, 1, 4'h3, 0);
    cyc("r2_n3", 0, 16'h0, 3'd0, 0, 1, 4'h1, 1);
    idle_chk("r2", 16'd1, 1'b0);

    // counter saturation with single-nibble words, one per cycle
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'h0001; in_nibbles = 3'd1; fifo_in_stall = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("sat_pre", 32'(words_sent), 32'h0000FFFE);
    repeat (5) @(negedge clk);
    #1;
    chk("sat_full", 32'(words_sent), 32'h0000FFFF);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("sat_hold", 32'(words_sent), 32'h0000FFFF);
    chk("sat_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
